// File: rtl/pingpong_param.sv
// Parametrised bounce/wrap counter with runtime bounds, programmable step, hold/flip control and bound flags.
// Optional feature: define PP_TURN_CNT_EN to add the saturating bounce turnaround counter output turn_cnt.
module pingpong_param #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned DEF_LO = 0,
    parameter int unsigned DEF_HI = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flip,
    input  logic             mode,
    input  logic [WIDTH-1:0] step,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_lo,
    input  logic [WIDTH-1:0] ld_hi,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             max,
    output logic             min,
    output logic             cfg_err
`ifdef PP_TURN_CNT_EN
    ,
    output logic [7:0]       turn_cnt
`endif
);

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_BOUNCE = 1'b0,
        MODE_WRAP   = 1'b1
    } mode_e;

    localparam logic [WIDTH-1:0] RST_LO = WIDTH'(DEF_LO);
    localparam logic [WIDTH-1:0] RST_HI = WIDTH'(DEF_HI);

    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] hi_q;

    logic             eff_up;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic             at_hi;
    logic             at_lo;
    logic             load_ok;
    logic [WIDTH-1:0] next_out;
    dir_e             next_dir;
    logic             turn;

    // Saturating arithmetic is done one bit wider so neither direction can wrap past 0 or 2**WIDTH-1.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next_out = out;
        next_dir = dir_e'(dir);
        turn     = 1'b0;

        eff_up   = dir ^ flip;
        step_ext = (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
        up_sum   = {1'b0, out} + step_ext;
        up_val   = (up_sum > {1'b0, hi_q}) ? hi_q : up_sum[WIDTH-1:0];
        dn_val   = ({1'b0, out} < ({1'b0, lo_q} + step_ext)) ? lo_q
                                                             : (out - step_ext[WIDTH-1:0]);
        at_hi    = (out >= hi_q);
        at_lo    = (out <= lo_q);
        load_ok  = (ld_lo <= ld_hi);

        if (mode_e'(mode) == MODE_BOUNCE) begin
            if (eff_up) begin
                if (at_hi) begin
                    next_out = dn_val;
                    next_dir = DIR_DOWN;
                    turn     = 1'b1;
                end else begin
                    next_out = up_val;
                    next_dir = DIR_UP;
                end
            end else begin
                if (at_lo) begin
                    next_out = up_val;
                    next_dir = DIR_UP;
                    turn     = 1'b1;
                end else begin
                    next_out = dn_val;
                    next_dir = DIR_DOWN;
                end
            end
        end else begin
            if (eff_up) begin
                next_out = at_hi ? lo_q : up_val;
            end else begin
                next_out = at_lo ? hi_q : dn_val;
            end
            next_dir = eff_up ? DIR_UP : DIR_DOWN;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out     <= RST_LO;
            dir     <= DIR_UP;
            lo_q    <= RST_LO;
            hi_q    <= RST_HI;
            cfg_err <= 1'b0;
        end else if (ld_en) begin
            if (load_ok) begin
                lo_q    <= ld_lo;
                hi_q    <= ld_hi;
                out     <= ld_lo;
                dir     <= DIR_UP;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end else begin
            cfg_err <= 1'b0;
            if (!hold) begin
                out <= next_out;
                dir <= next_dir;
            end
        end
    end

    assign max = (out == hi_q);
    assign min = (out == lo_q);

`ifdef PP_TURN_CNT_EN
    // Only bound-triggered reversals in bounce mode count; flip-driven reversals never set turn.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            turn_cnt <= '0;
        end else if (ld_en) begin
            if (load_ok) begin
                turn_cnt <= '0;
            end
        end else if (!hold && turn && (turn_cnt != 8'hFF)) begin
            turn_cnt <= turn_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pingpong_param.sv
// Self-checking bench for pingpong_param: directed scenarios with literal expectations plus
// randomized stimulus compared every cycle against an integer behavioural model.
module tb_pingpong_param;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         hold;
    logic         flip;
    logic         mode;
    logic [W-1:0] step;
    logic         ld_en;
    logic [W-1:0] ld_lo;
    logic [W-1:0] ld_hi;
    logic [W-1:0] out;
    logic         dir;
    logic         pp_max;
    logic         pp_min;
    logic         cfg_err;
`ifdef PP_TURN_CNT_EN
    logic [7:0]   turn_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    int m_out, m_dir, m_lo, m_hi, m_err;

    always #5 clk = ~clk;

    pingpong_param #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .hold    (hold),
        .flip    (flip),
        .mode    (mode),
        .step    (step),
        .ld_en   (ld_en),
        .ld_lo   (ld_lo),
        .ld_hi   (ld_hi),
        .out     (out),
        .dir     (dir),
        .max     (pp_max),
        .min     (pp_min),
        .cfg_err (cfg_err)
`ifdef PP_TURN_CNT_EN
        ,
        .turn_cnt(turn_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock of the model, computed from the rules with plain integers, then the edge itself.
    task automatic tick();
        int n_out, n_dir, n_lo, n_hi, n_err, s, d;
        n_out = m_out; n_dir = m_dir; n_lo = m_lo; n_hi = m_hi; n_err = 0;
        s = (step == 0) ? 1 : int'(step);
        d = m_dir ^ int'(flip);
        if (!rst_n) begin
            n_out = 0; n_dir = 1; n_lo = 0; n_hi = 2**W - 1;
        end else if (ld_en) begin
            if (ld_lo <= ld_hi) begin
                n_lo = ld_lo; n_hi = ld_hi; n_out = ld_lo; n_dir = 1;
            end else begin
                n_err = 1;
            end
        end else if (!hold) begin
            if (!mode) begin
                if (d == 1) begin
                    if (m_out >= m_hi) begin n_out = imax(m_out - s, m_lo); n_dir = 0; end
                    else               begin n_out = imin(m_out + s, m_hi); n_dir = 1; end
                end else begin
                    if (m_out <= m_lo) begin n_out = imin(m_out + s, m_hi); n_dir = 1; end
                    else               begin n_out = imax(m_out - s, m_lo); n_dir = 0; end
                end
            end else begin
                if (d == 1) n_out = (m_out >= m_hi) ? m_lo : imin(m_out + s, m_hi);
                else        n_out = (m_out <= m_lo) ? m_hi : imax(m_out - s, m_lo);
                n_dir = d;
            end
        end
        @(posedge clk);
        m_out = n_out; m_dir = n_dir; m_lo = n_lo; m_hi = n_hi; m_err = n_err;
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_out",     32'(out),     32'(m_out));
            check("m_dir",     32'(dir),     32'(m_dir));
            check("m_max",     32'(pp_max),  32'(m_out == m_hi));
            check("m_min",     32'(pp_min),  32'(m_out == m_lo));
            check("m_cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic load(input int lo, input int hi);
        ld_en = 1'b1; ld_lo = W'(lo); ld_hi = W'(hi);
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        int seq4[5] = '{7, 9, 5, 3, 7};
        int seq5[4] = '{5, 6, 2, 5};

        rst_n = 1'b0; hold = 1'b0; flip = 1'b0; mode = 1'b0; step = W'(1);
        ld_en = 1'b0; ld_lo = '0; ld_hi = '0;
        m_out = 0; m_dir = 1; m_lo = 0; m_hi = 0; m_err = 0;
        tick();
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Reset state
        check("rst_out", 32'(out), 0);
        check("rst_dir", 32'(dir), 1);
        check("rst_min", 32'(pp_min), 1);
        check("rst_max", 32'(pp_max), 0);
        check("rst_err", 32'(cfg_err), 0);

        // Bounce sweep over default bounds
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("up_out", 32'(out), 32'(i));
            check("up_max", 32'(pp_max), 32'(i == 15));
        end
        check("top_dir", 32'(dir), 1);
        for (int i = 14; i >= 0; i--) begin
            tick();
            check("dn_out", 32'(out), 32'(i));
            check("dn_dir", 32'(dir), 0);
            check("dn_min", 32'(pp_min), 32'(i == 0));
        end
        tick();
        check("bot_out", 32'(out), 1);
        check("bot_dir", 32'(dir), 1);

        // Hold with flip pulsed inside
        repeat (4) tick();
        check("pre_hold", 32'(out), 5);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flip = (i == 1);
            tick();
            check("hold_out", 32'(out), 5);
            check("hold_dir", 32'(dir), 1);
        end
        hold = 1'b0; flip = 1'b0;
        tick();
        check("resume", 32'(out), 6);

        // Flip reversal mid-sweep and at the top bound
        tick();
        check("at7", 32'(out), 7);
        flip = 1'b1;
        tick();
        check("flip7_out", 32'(out), 6);
        check("flip7_dir", 32'(dir), 0);
        flip = 1'b0;
        load(0, 15);
        mode = 1'b1; flip = 1'b1;
        tick();
        check("wrapdn_out", 32'(out), 15);
        check("wrapdn_dir", 32'(dir), 0);
        mode = 1'b0;
        tick();
        check("flip15_out", 32'(out), 14);
        check("flip15_dir", 32'(dir), 0);
        flip = 1'b0;

        // Narrow bounce with step 4
        step = W'(4);
        load(3, 9);
        check("ld_out", 32'(out), 3);
        foreach (seq4[i]) begin
            tick();
            check("b4_out", 32'(out), 32'(seq4[i]));
        end

        // Wrap mode with step 3
        mode = 1'b1; step = W'(3);
        load(2, 6);
        check("w_ld", 32'(out), 2);
        foreach (seq5[i]) begin
            tick();
            check("w_out", 32'(out), 32'(seq5[i]));
            check("w_dir", 32'(dir), 1);
            check("w_max", 32'(pp_max), 32'(seq5[i] == 6));
        end

        // Rejected load, then reset mid-sweep
        mode = 1'b0; step = W'(1);
        load(9, 3);
        check("rej_err", 32'(cfg_err), 1);
        check("rej_out", 32'(out), 5);
        tick();
        check("rej_clr", 32'(cfg_err), 0);
        check("rej_hi", 32'(out), 6);
        check("rej_max", 32'(pp_max), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_out", 32'(out), 0);
        check("mid_rst_dir", 32'(dir), 1);

        // Randomized stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            hold  = ($urandom_range(0, 7) == 0);
            flip  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0) step = W'($urandom_range(0, 2**W - 1));
            ld_en = ($urandom_range(0, 23) == 0);
            ld_lo = W'($urandom_range(0, 2**W - 1));
            ld_hi = ($urandom_range(0, 3) == 0) ? ld_lo : W'($urandom_range(0, 2**W - 1));
            tick();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
